tx_packet_arbiter: RTL and testbench
====================================

TX_PACKET_ARBITER -- requirements
Module: tx_packet_arbiter

Interface
REQ-001 SHALL have parameter APPEND_CSUM, default 1: when 1, an XOR checksum byte is sent after each packet's last byte.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each: requester byte valid.
REQ-005 SHALL have ports req0_data/req1_data, input, 8 each: requester byte.
REQ-006 SHALL have ports req0_last/req1_last, input, 1 each: byte is the final payload byte of its packet.
REQ-007 SHALL have ports req0_ready/req1_ready, output, 1 each: arbiter accepts a byte when valid&ready.
REQ-008 SHALL have port tx_byte, output, 8: byte to uart_tx, held stable from tx_en until the next load.
REQ-009 SHALL have port tx_en, output, 1: registered single-cycle start strobe to uart_tx.
REQ-010 SHALL have port tx_busy, input, 1: uart_tx busy; rises one cycle after tx_en and falls after the stop bit.
REQ-011 SHALL have port grant, output, 2: one-hot current packet owner (bit0 = req0); 00 when idle.
REQ-012 SHALL have port pkt_done, output, 1: one-cycle pulse when a packet, including any checksum, has fully left uart_tx.

Function
REQ-013 SHALL implement states IDLE, FETCH, WAIT_HI, WAIT_LO, CSUM.
REQ-014 IDLE: with tx_busy=0 and at least one reqN_valid, SHALL set grant and enter FETCH on the next cycle; with tx_busy=1, SHALL grant nothing.
REQ-015 Arbitration SHALL be round-robin at packet granularity. A priority pointer selects between two simultaneous requests. A lone valid requester SHALL win regardless of the pointer.
REQ-016 On pkt_done, the priority pointer SHALL point to the requester that did not just complete.
REQ-017 Grant SHALL be held for the whole packet. The non-granted reqN_ready SHALL stay 0 throughout.
REQ-018 FETCH: the granted reqN_ready SHALL be 1, combinationally from state and grant. In all other states both readies SHALL be 0.
REQ-019 FETCH: if the granted valid is 0, SHALL wait indefinitely with grant held.
REQ-020 A handshake in cycle N SHALL load tx_byte, XOR the byte into the checksum, latch last, and drive tx_en=1 in cycle N+1 only; state SHALL move to WAIT_HI.
REQ-021 WAIT_HI SHALL wait for tx_busy=1, then enter WAIT_LO. WAIT_LO SHALL wait for tx_busy=0.
REQ-022 On tx_busy=0 in WAIT_LO, the next state SHALL be:
- not last: FETCH
- last and APPEND_CSUM=1 and checksum not yet sent: CSUM
- otherwise: pulse pkt_done, clear grant, enter IDLE
REQ-023 CSUM SHALL load tx_byte with the checksum, pulse tx_en for one cycle, mark the checksum as sent, and enter WAIT_HI.
REQ-024 The checksum SHALL be an 8-bit XOR of all payload bytes of the current packet. It SHALL initialise to 0x00 at each grant.
REQ-025 tx_en SHALL never be asserted while tx_busy=1 or within WAIT_HI/WAIT_LO; at most one tx_en SHALL occur per uart_tx frame.
REQ-026 A single-byte packet (last on the first byte) SHALL be legal; its checksum equals that byte.

Reset
REQ-027 rst=1 SHALL force, on the next edge: state IDLE, tx_en=0, tx_byte=0x00, grant=00, pkt_done=0, both readies=0, checksum=0x00, priority pointer to req0.
REQ-028 Reset mid-packet SHALL drop the remainder of the packet. After reset, no grant SHALL occur until tx_busy=0, since uart_tx is unaffected by rst.

Verification
REQ-029 req0 sends 0x55, then 0xA3 with last, APPEND_CSUM=1 -> tx_en pulses carry 0x55, 0xA3, 0xF6 in order; grant=01 throughout; one pkt_done after the final busy fall.
REQ-030 Both requesters continuously valid with 1-byte packets after reset -> packet order req0, req1, req0, req1; ready never high for the non-granted requester.
REQ-031 Real uart_tx with CLKS_PER_BIT=4 -> successive tx_en pulses at least 40 cycles apart; none while tx_busy=1.
REQ-032 req0 valid dropped for 10 cycles mid-packet while req1 is valid -> FETCH holds grant=01; req1 is not served until req0's pkt_done.
REQ-033 rst pulsed while tx_busy=1 mid-packet -> outputs at reset values the next cycle; a pending request is granted only after tx_busy falls; priority is req0.
REQ-034 APPEND_CSUM=0, req1 single byte 0x7E with last -> exactly one tx_en with 0x7E, then pkt_done.

Source files
------------

// File: rtl/tx_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tx_packet_arbiter
//
// Purpose:
//   Shares one uart_tx between two byte-stream requesters. Ownership is
//   granted per packet, round-robin between the requesters. Each accepted
//   byte is loaded into tx_byte and started with a single-cycle tx_en. The
//   arbiter then follows tx_busy through one full frame before it fetches
//   the next byte. When APPEND_CSUM is set, an XOR checksum byte is sent
//   after the last payload byte of each packet.
//
// Parameters:
//   APPEND_CSUM  1: send an XOR checksum byte after each packet, 0: do not
//
// Ports:
//   clk                     single clock, rising edge
//   rst                     synchronous active-high reset
//   req0_valid/req1_valid   requester byte valid
//   req0_data/req1_data     requester byte
//   req0_last/req1_last     byte is the final payload byte of the packet
//   req0_ready/req1_ready   byte accepted when valid & ready
//   tx_byte                 byte to uart_tx, stable from tx_en until next load
//   tx_en                   registered single-cycle start strobe to uart_tx
//   tx_busy                 uart_tx busy, rises one cycle after tx_en
//   grant                   one-hot packet owner (bit0 = req0), 00 when idle
//   pkt_done                one-cycle pulse when a packet has fully left uart_tx
//
// States:
//   state   | meaning
//   IDLE    | no owner; grant when uart_tx is free and someone is valid
//   FETCH   | owner's ready is high; wait for its byte
//   WAIT_HI | byte started; wait for uart_tx to report busy
//   WAIT_LO | frame in flight; wait for uart_tx to go idle
//   CSUM    | start the checksum byte of the finished packet
// ---------------------------------------------------------------------------
module tx_packet_arbiter #(
  parameter int APPEND_CSUM = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_byte,
  output logic       tx_en,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       pkt_done
);

  localparam logic C_APPEND = (APPEND_CSUM != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    CSUM    = 3'd4
  } state_t;

  state_t     r_state,     w_state_nxt;
  logic [1:0] r_grant,     w_grant_nxt;
  logic       r_ptr,       w_ptr_nxt;       // 0: req0 has priority, 1: req1
  logic [7:0] r_csum,      w_csum_nxt;
  logic       r_last,      w_last_nxt;
  logic       r_csum_sent, w_csum_sent_nxt;
  logic [7:0] r_tx_byte,   w_tx_byte_nxt;
  logic       r_tx_en,     w_tx_en_nxt;
  logic       r_pkt_done,  w_pkt_done_nxt;

  logic       w_pick0;
  logic       w_pick1;
  logic       w_sel_valid;
  logic [7:0] w_sel_data;
  logic       w_sel_last;
  logic       w_in_fetch;
  logic       w_hs;

  // A lone requester always wins; the pointer only breaks ties.
  assign w_pick0 = req0_valid & (~req1_valid | ~r_ptr);
  assign w_pick1 = req1_valid & ~w_pick0;

  // Owner's byte stream, selected by the held grant.
  assign w_sel_valid = r_grant[1] ? req1_valid : (r_grant[0] & req0_valid);
  assign w_sel_data  = r_grant[1] ? req1_data  : req0_data;
  assign w_sel_last  = r_grant[1] ? req1_last  : req0_last;

  assign w_in_fetch = (r_state == FETCH);
  assign w_hs       = w_in_fetch & w_sel_valid;

  assign req0_ready = w_in_fetch & r_grant[0];
  assign req1_ready = w_in_fetch & r_grant[1];

  assign tx_byte  = r_tx_byte;
  assign tx_en    = r_tx_en;
  assign grant    = r_grant;
  assign pkt_done = r_pkt_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= 2'b00;
      r_ptr       <= 1'b0;
      r_csum      <= 8'h00;
      r_last      <= 1'b0;
      r_csum_sent <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_tx_en     <= 1'b0;
      r_pkt_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_csum      <= w_csum_nxt;
      r_last      <= w_last_nxt;
      r_csum_sent <= w_csum_sent_nxt;
      r_tx_byte   <= w_tx_byte_nxt;
      r_tx_en     <= w_tx_en_nxt;
      r_pkt_done  <= w_pkt_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_ptr_nxt       = r_ptr;
    w_csum_nxt      = r_csum;
    w_last_nxt      = r_last;
    w_csum_sent_nxt = r_csum_sent;
    w_tx_byte_nxt   = r_tx_byte;
    w_tx_en_nxt     = 1'b0;
    w_pkt_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        // uart_tx is not reset with us, so a frame may still be in flight.
        if (!tx_busy && (req0_valid || req1_valid)) begin
          w_grant_nxt     = {w_pick1, w_pick0};
          w_csum_nxt      = 8'h00;
          w_csum_sent_nxt = 1'b0;
          w_last_nxt      = 1'b0;
          w_state_nxt     = FETCH;
        end
      end

      FETCH: begin
        if (w_hs) begin
          w_tx_byte_nxt = w_sel_data;
          w_csum_nxt    = r_csum ^ w_sel_data;
          w_last_nxt    = w_sel_last;
          w_tx_en_nxt   = 1'b1;
          w_state_nxt   = WAIT_HI;
        end
      end

      WAIT_HI: begin
        if (tx_busy) begin
          w_state_nxt = WAIT_LO;
        end
      end

      WAIT_LO: begin
        if (!tx_busy) begin
          if (!r_last) begin
            w_state_nxt = FETCH;
          end else if (C_APPEND && !r_csum_sent) begin
            w_state_nxt = CSUM;
          end else begin
            w_pkt_done_nxt = 1'b1;
            w_grant_nxt    = 2'b00;
            // Hand priority to whoever did not just finish.
            w_ptr_nxt      = r_grant[0];
            w_state_nxt    = IDLE;
          end
        end
      end

      CSUM: begin
        w_tx_byte_nxt   = r_csum;
        w_tx_en_nxt     = 1'b1;
        w_csum_sent_nxt = 1'b1;
        w_state_nxt     = WAIT_HI;
      end

      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tx_packet_arbiter
//
// Directed bench for tx_packet_arbiter. A behavioural uart_tx busy model
// (40-cycle frame, i.e. 10 bits at 4 clocks per bit) closes the loop. Queued
// requester drivers present bytes, and a monitor records every tx_en byte,
// every new grant and every pkt_done. A second instance with APPEND_CSUM=0
// covers the no-checksum case.
// ---------------------------------------------------------------------------
module tb_tx_packet_arbiter;

  localparam int FRAME = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_last, req1_last;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_byte;
  logic       tx_en;
  logic       tx_busy;
  logic [1:0] grant;
  logic       pkt_done;

  // second instance, APPEND_CSUM = 0
  logic       b_z_valid;
  logic [7:0] b_z_data;
  logic       b_z_last;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_last;
  logic       b_r0, b_r1;
  logic [7:0] b_tx_byte;
  logic       b_tx_en;
  logic       b_busy;
  logic [1:0] b_grant;
  logic       b_pkt_done;

  int total = 0;
  int bad   = 0;

  tx_packet_arbiter #(.APPEND_CSUM(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_byte(tx_byte), .tx_en(tx_en), .tx_busy(tx_busy), .grant(grant), .pkt_done(pkt_done)
  );

  tx_packet_arbiter #(.APPEND_CSUM(0)) dut_nc (
    .clk(clk), .rst(rst),
    .req0_valid(b_z_valid), .req0_data(b_z_data), .req0_last(b_z_last), .req0_ready(b_r0),
    .req1_valid(b_valid), .req1_data(b_data), .req1_last(b_last), .req1_ready(b_r1),
    .tx_byte(b_tx_byte), .tx_en(b_tx_en), .tx_busy(b_busy), .grant(b_grant), .pkt_done(b_pkt_done)
  );

  // uart_tx busy models: busy for FRAME cycles starting the cycle after tx_en
  int busy_cnt = 0;
  int b_cnt    = 0;
  always @(posedge clk) begin
    if (tx_en) busy_cnt <= FRAME;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (b_tx_en) b_cnt <= FRAME;
    else if (b_cnt > 0) b_cnt <= b_cnt - 1;
  end
  assign tx_busy = (busy_cnt > 0);
  assign b_busy  = (b_cnt > 0);

  // monitor
  int         cyc = 0;
  logic [7:0] txb[$];
  logic [1:0] txg[$];
  logic [1:0] gq[$];
  int         n_done = 0;
  int         bad_ready = 0;
  int         bad_txen_busy = 0;
  int         bad_txen_long = 0;
  int         last_txen_cyc = -100000;
  int         min_gap = 1000000;
  logic [1:0] prev_grant = 2'b00;
  logic       prev_txen = 1'b0;
  int         b_ntx = 0;
  int         b_ndone = 0;
  logic [7:0] b_last_byte = 8'h00;
  logic [1:0] b_last_grant = 2'b00;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_en) begin
      txb.push_back(tx_byte);
      txg.push_back(grant);
      if (cyc - last_txen_cyc < min_gap) min_gap = cyc - last_txen_cyc;
      last_txen_cyc = cyc;
      if (tx_busy) bad_txen_busy = bad_txen_busy + 1;
      if (prev_txen) bad_txen_long = bad_txen_long + 1;
    end
    prev_txen = tx_en;
    if (pkt_done) n_done = n_done + 1;
    if (grant != 2'b00 && prev_grant == 2'b00) gq.push_back(grant);
    prev_grant = grant;
    if (req0_ready && grant != 2'b01) bad_ready = bad_ready + 1;
    if (req1_ready && grant != 2'b10) bad_ready = bad_ready + 1;
    if (b_tx_en) begin
      b_ntx = b_ntx + 1;
      b_last_byte = b_tx_byte;
      b_last_grant = b_grant;
    end
    if (b_pkt_done) b_ndone = b_ndone + 1;
  end

  // requester queues: {last, data}
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       hold0 = 1'b0;

  task automatic drive_loop;
    bit hs0, hs1;
    forever begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0 && !hold0) begin
        req0_valid = 1'b1; req0_data = q0[0][7:0]; req0_last = q0[0][8];
      end else begin
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
      end
      if (q1.size() > 0) begin
        req1_valid = 1'b1; req1_data = q1[0][7:0]; req1_last = q1[0][8];
      end else begin
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
    total++; if (pkt_done !== 1'b0) begin bad++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
    total++; if ({req1_ready, req0_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready}); end
    total++; if ({b_tx_en, b_grant} !== 3'b000) begin bad++; $display("FAIL reset_nc: got %b want 000", {b_tx_en, b_grant}); end
    rst = 1'b0;
  endtask

  task automatic test_two_byte_csum;
    int d0, t0, g0;
    bit ok;
    logic [7:0] exp_b [3];
    exp_b = '{8'h55, 8'hA3, 8'hF6};
    d0 = n_done; t0 = txb.size(); g0 = gq.size();
    q0.push_back({1'b0, 8'h55});
    q0.push_back({1'b1, 8'hA3});
    wait_done(d0 + 1, 1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL csum_timeout: pkt_done not seen, got %0d want %0d", n_done - d0, 1); end
    repeat (5) @(negedge clk);
    total++;
    if (txb.size() - t0 != 3) begin
      bad++; $display("FAIL csum_count: got %0d tx_en want 3", txb.size() - t0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (txb[t0 + i] !== exp_b[i]) begin bad++; $display("FAIL csum_byte%0d: got %h want %h", i, txb[t0 + i], exp_b[i]); end
        total++;
        if (txg[t0 + i] !== 2'b01) begin bad++; $display("FAIL csum_grant%0d: got %b want 01", i, txg[t0 + i]); end
      end
    end
    total++; if (n_done - d0 != 1) begin bad++; $display("FAIL csum_done_count: got %0d want 1", n_done - d0); end
    total++;
    if (gq.size() - g0 != 1) begin bad++; $display("FAIL csum_grants: got %0d want 1", gq.size() - g0); end
    else if (gq[g0] !== 2'b01) begin bad++; $display("FAIL csum_owner: got %b want 01", gq[g0]); end
  endtask

  task automatic test_round_robin;
    int d0, t0, g0;
    bit ok;
    logic [7:0] exp_b [8];
    logic [1:0] exp_g [4];
    exp_b = '{8'h11, 8'h11, 8'h33, 8'h33, 8'h22, 8'h22, 8'h44, 8'h44};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    // previous packet was req0's, so without a reset req1 would be first
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    d0 = n_done; t0 = txb.size(); g0 = gq.size();
    q0.push_back({1'b1, 8'h11}); q0.push_back({1'b1, 8'h22});
    q1.push_back({1'b1, 8'h33}); q1.push_back({1'b1, 8'h44});
    wait_done(d0 + 4, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_timeout: got %0d packets want 4", n_done - d0); end
    repeat (3) @(negedge clk);
    total++;
    if (gq.size() - g0 != 4) begin
      bad++; $display("FAIL rr_grant_count: got %0d want 4", gq.size() - g0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (gq[g0 + i] !== exp_g[i]) begin bad++; $display("FAIL rr_order%0d: got %b want %b", i, gq[g0 + i], exp_g[i]); end
      end
    end
    total++;
    if (txb.size() - t0 != 8) begin
      bad++; $display("FAIL rr_tx_count: got %0d want 8", txb.size() - t0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (txb[t0 + i] !== exp_b[i]) begin bad++; $display("FAIL rr_byte%0d: got %h want %h", i, txb[t0 + i], exp_b[i]); end
      end
    end
    total++; if (bad_ready != 0) begin bad++; $display("FAIL rr_ready_leak: got %0d want 0", bad_ready); end
  endtask

  task automatic test_valid_drop;
    int d0, t0, g0, viol;
    bit ok;
    logic [7:0] exp_b [6];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD0, 8'hD4, 8'hD4};
    d0 = n_done; t0 = txb.size(); g0 = gq.size();
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hB2}); q0.push_back({1'b1, 8'hC3});
    q1.push_back({1'b1, 8'hD4});
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txb.size() > t0) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL drop_first_byte: got %0d tx_en want 1", txb.size() - t0); end
    hold0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req0_ready) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL drop_fetch: req0_ready got 0 want 1"); end
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant !== 2'b01 || req1_ready !== 1'b0 || tx_en !== 1'b0 || req0_ready !== 1'b1) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL drop_hold: got %0d bad cycles want 0", viol); end
    total++; if (gq.size() - g0 != 1) begin bad++; $display("FAIL drop_regrant: got %0d grants want 1", gq.size() - g0); end
    hold0 = 1'b0;
    wait_done(d0 + 2, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_timeout: got %0d packets want 2", n_done - d0); end
    repeat (3) @(negedge clk);
    total++;
    if (gq.size() - g0 != 2) begin bad++; $display("FAIL drop_grants: got %0d want 2", gq.size() - g0); end
    else if (gq[g0] !== 2'b01 || gq[g0 + 1] !== 2'b10) begin
      bad++; $display("FAIL drop_order: got %b,%b want 01,10", gq[g0], gq[g0 + 1]);
    end
    total++;
    if (txb.size() - t0 != 6) begin
      bad++; $display("FAIL drop_tx_count: got %0d want 6", txb.size() - t0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (txb[t0 + i] !== exp_b[i]) begin bad++; $display("FAIL drop_byte%0d: got %h want %h", i, txb[t0 + i], exp_b[i]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int d0, t0, t1, g1, viol;
    bit ok;
    logic [7:0] exp_b [4];
    exp_b = '{8'h71, 8'h71, 8'h62, 8'h62};
    // a req0 packet first so that the pointer favours req1 before reset
    d0 = n_done;
    q0.push_back({1'b1, 8'h5A});
    wait_done(d0 + 1, 500, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_pre: got %0d packets want 1", n_done - d0); end
    t0 = txb.size();
    q1.push_back({1'b0, 8'h61}); q1.push_back({1'b1, 8'h62});
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txb.size() > t0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL rmid_start: got no tx_en want 1"); end
    else if (txb[t0] !== 8'h61) begin bad++; $display("FAIL rmid_first: got %h want 61", txb[t0]); end
    repeat (3) @(negedge clk);
    total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL rmid_busy: got %b want 1", tx_busy); end
    rst = 1'b1;
    q0.push_back({1'b1, 8'h71});
    @(negedge clk);
    total++; if ({tx_en, grant, pkt_done, req1_ready, req0_ready} !== 6'b000000) begin
      bad++; $display("FAIL rmid_outputs: got %b want 000000", {tx_en, grant, pkt_done, req1_ready, req0_ready});
    end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL rmid_tx_byte: got %h want 00", tx_byte); end
    rst = 1'b0;
    t1 = txb.size(); g1 = gq.size(); d0 = n_done;
    viol = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant !== 2'b00 || tx_en !== 1'b0) viol++;
      if (!tx_busy) begin ok = 1'b1; break; end
    end
    total++; if (!ok || viol != 0) begin bad++; $display("FAIL rmid_wait_busy: got %0d early grants (idle %b) want 0", viol, ok); end
    wait_done(d0 + 2, 1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_timeout: got %0d packets want 2", n_done - d0); end
    repeat (3) @(negedge clk);
    total++;
    if (gq.size() - g1 != 2) begin bad++; $display("FAIL rmid_grants: got %0d want 2", gq.size() - g1); end
    else if (gq[g1] !== 2'b01 || gq[g1 + 1] !== 2'b10) begin
      bad++; $display("FAIL rmid_priority: got %b,%b want 01,10", gq[g1], gq[g1 + 1]);
    end
    total++;
    if (txb.size() - t1 != 4) begin
      bad++; $display("FAIL rmid_tx_count: got %0d want 4", txb.size() - t1);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (txb[t1 + i] !== exp_b[i]) begin bad++; $display("FAIL rmid_byte%0d: got %h want %h", i, txb[t1 + i], exp_b[i]); end
      end
    end
  endtask

  task automatic test_no_csum;
    bit ok;
    @(negedge clk);
    b_valid = 1'b1; b_data = 8'h7E; b_last = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_r1) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL nc_ready: got 0 want 1"); end
    @(posedge clk);
    #1;
    b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_ndone >= 1) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL nc_timeout: got %0d pkt_done want 1", b_ndone); end
    repeat (60) @(negedge clk);
    total++; if (b_ntx != 1) begin bad++; $display("FAIL nc_tx_count: got %0d want 1", b_ntx); end
    total++; if (b_last_byte !== 8'h7E) begin bad++; $display("FAIL nc_byte: got %h want 7e", b_last_byte); end
    total++; if (b_last_grant !== 2'b10) begin bad++; $display("FAIL nc_grant: got %b want 10", b_last_grant); end
    total++; if (b_ndone != 1) begin bad++; $display("FAIL nc_done_count: got %0d want 1", b_ndone); end
  endtask

  task automatic test_tx_spacing;
    total++; if (min_gap < FRAME) begin bad++; $display("FAIL spacing_gap: got %0d want >= %0d", min_gap, FRAME); end
    total++; if (bad_txen_busy != 0) begin bad++; $display("FAIL spacing_busy: got %0d tx_en while busy want 0", bad_txen_busy); end
    total++; if (bad_txen_long != 0) begin bad++; $display("FAIL spacing_width: got %0d long tx_en want 0", bad_txen_long); end
    total++; if (bad_ready != 0) begin bad++; $display("FAIL spacing_ready: got %0d want 0", bad_ready); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    b_z_valid = 1'b0; b_z_data = 8'h00; b_z_last = 1'b0;
    b_valid = 1'b0; b_data = 8'h00; b_last = 1'b0;
    fork
      drive_loop();
    join_none
    test_reset();
    test_two_byte_csum();
    test_round_robin();
    test_valid_drop();
    test_reset_mid();
    test_no_csum();
    test_tx_spacing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
